// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the processor run controller: state encoding,
// counter width and a saturating increment helper.
package proc_ctrl_pkg;

   localparam int unsigned CNT_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_e;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         return v;
      end
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/trig_sync.sv
// Synchronizes the asynchronous active-low trigger pin into the clk domain and
// produces a registered one-cycle pulse on each falling edge of the synced level.
// A pin already low when reset releases is not treated as a press: the detector
// arms only after the synchronized level has been seen high at least once.
module trig_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic trigger,
   output logic trig_fall
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   // Tracks which synchronizer stages hold a real pin sample since reset.
   logic [SYNC_STAGES-1:0] vld_q, vld_d;
   logic                   prev_q, prev_d;
   logic                   armed_q, armed_d;
   logic                   fall_q, fall_d;
   logic                   sync_last;
   logic                   sync_last_vld;

   assign sync_last     = sync_q[SYNC_STAGES-1];
   assign sync_last_vld = vld_q[SYNC_STAGES-1];

   // Next-state for synchronizer chain, edge history, arming and pulse.
   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], trigger};
      vld_d   = {vld_q[SYNC_STAGES-2:0], 1'b1};
      prev_d  = sync_last;
      armed_d = armed_q | (sync_last_vld & sync_last);
      fall_d  = armed_q & prev_q & ~sync_last;
   end

   // Synchronizer flops; reset makes the pin look released (idle high).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q  <= '1;
         vld_q   <= '0;
         prev_q  <= 1'b1;
         armed_q <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         vld_q   <= vld_d;
         prev_q  <= prev_d;
         armed_q <= armed_d;
         fall_q  <= fall_d;
      end
   end

   assign trig_fall = fall_q;

endmodule

// File: rtl/proc_run_ctrl.sv
// Run controller for the processor: a trigger press starts a run, which ends on
// a fetched all-zero instruction or when the watchdog cycle limit is reached.
// Counts enabled and stalled cycles of the current or last run.
module proc_run_ctrl
   import proc_ctrl_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [31:0] WDOG_LIMIT  = 32'h00FF_FFFF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             trigger,
   input  logic [31:0]      inst_word,
   input  logic             data_stall,
   input  logic             du_stall,
   output logic             run_en,
   output logic             proc_en,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [CNT_W-1:0] WDOG_LAST = WDOG_LIMIT - 32'd1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             timeout_q, timeout_d;

   logic             trig_fall;
   logic             start;
   logic             halt_inst;
   logic             halt_wdog;

   trig_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_trig_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .trigger   (trigger),
      .trig_fall (trig_fall)
   );

   // A press is honoured from IDLE or HALT only; presses during RUN are dropped.
   assign start     = trig_fall & (state_q != RUN);
   assign halt_inst = proc_en & (inst_word == 32'h0);
   assign halt_wdog = proc_en & (cyc_q == WDOG_LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (halt_inst || halt_wdog) begin
               state_d = HALT;
            end
         end
         HALT: begin
            if (start) begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from state; proc_en alone sees the stall inputs directly.
   always_comb begin
      run_en  = (state_q == RUN);
      busy    = run_en;
      done    = (state_q == HALT);
      proc_en = run_en & ~(data_stall | du_stall);
   end

   // Counter and timeout next-state: clear on start, count only while running.
   always_comb begin
      cyc_d     = cyc_q;
      stall_d   = stall_q;
      timeout_d = timeout_q;
      if (start) begin
         cyc_d     = '0;
         stall_d   = '0;
         timeout_d = 1'b0;
      end else if (run_en) begin
         if (proc_en) begin
            cyc_d = sat_inc(cyc_q);
         end else begin
            stall_d = sat_inc(stall_q);
         end
         if (halt_wdog) begin
            timeout_d = 1'b1;
         end
      end
   end

   // Counter and timeout registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cyc_q     <= '0;
         stall_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         cyc_q     <= cyc_d;
         stall_q   <= stall_d;
         timeout_q <= timeout_d;
      end
   end

   assign cyc_cnt   = cyc_q;
   assign stall_cnt = stall_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Directed bench for proc_run_ctrl with a short watchdog limit.
module tb_proc_run_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        trigger;
   logic [31:0] inst_word;
   logic        data_stall;
   logic        du_stall;
   logic        run_en;
   logic        proc_en;
   logic        busy;
   logic        done;
   logic        timeout;
   logic [31:0] cyc_cnt;
   logic [31:0] stall_cnt;

   int pass_cnt  = 0;
   int total_cnt = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   always #5 clk = ~clk;

   proc_run_ctrl #(
      .SYNC_STAGES (2),
      .WDOG_LIMIT  (32'd16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .trigger    (trigger),
      .inst_word  (inst_word),
      .data_stall (data_stall),
      .du_stall   (du_stall),
      .run_en     (run_en),
      .proc_en    (proc_en),
      .busy       (busy),
      .done       (done),
      .timeout    (timeout),
      .cyc_cnt    (cyc_cnt),
      .stall_cnt  (stall_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      trigger    = 1'b1;
      inst_word  = NOP;
      data_stall = 1'b0;
      du_stall   = 1'b0;
      ticks(3);
      if ({run_en, proc_en, busy, done} !== 4'b0000)
         $display("FAIL reset_outputs: got %b want 0000", {run_en, proc_en, busy, done});
      else pass_cnt++;
      total_cnt++;
      if ({timeout, cyc_cnt, stall_cnt} !== 65'd0)
         $display("FAIL reset_counters: got to=%b cyc=%0d st=%0d want 0 0 0",
                  timeout, cyc_cnt, stall_cnt);
      else pass_cnt++;
      total_cnt++;
      rst_n = 1'b1;
      ticks(6);
      if (busy !== 1'b0) $display("FAIL idle_after_reset: got busy=%b want 0", busy);
      else pass_cnt++;
      total_cnt++;
   endtask

   task automatic test_start_latency();
      trigger = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (run_en !== (k == 4))
            $display("FAIL start_edge%0d: got run_en=%b want %b", k, run_en, (k == 4));
         else pass_cnt++;
         total_cnt++;
      end
      if ({busy, done, proc_en} !== 3'b101)
         $display("FAIL start_flags: got busy/done/proc_en=%b want 101", {busy, done, proc_en});
      else pass_cnt++;
      total_cnt++;
      if (cyc_cnt !== 32'd0 || stall_cnt !== 32'd0)
         $display("FAIL start_counters: got cyc=%0d st=%0d want 0 0", cyc_cnt, stall_cnt);
      else pass_cnt++;
      total_cnt++;
      trigger = 1'b1;
   endtask

   task automatic test_halt_on_zero();
      ticks(10);
      if (cyc_cnt !== 32'd10) $display("FAIL run10_cyc: got %0d want 10", cyc_cnt);
      else pass_cnt++;
      total_cnt++;
      inst_word = 32'h0;
      #1;
      if (proc_en !== 1'b1) $display("FAIL halt_pre_proc_en: got %b want 1", proc_en);
      else pass_cnt++;
      total_cnt++;
      tick();
      if ({done, busy, run_en, proc_en, timeout} !== 5'b10000)
         $display("FAIL halt_flags: got done/busy/run/pe/to=%b want 10000",
                  {done, busy, run_en, proc_en, timeout});
      else pass_cnt++;
      total_cnt++;
      if (cyc_cnt !== 32'd11 || stall_cnt !== 32'd0)
         $display("FAIL halt_counters: got cyc=%0d st=%0d want 11 0", cyc_cnt, stall_cnt);
      else pass_cnt++;
      total_cnt++;
      ticks(3);
      if (cyc_cnt !== 32'd11 || done !== 1'b1)
         $display("FAIL halt_frozen: got cyc=%0d done=%b want 11 1", cyc_cnt, done);
      else pass_cnt++;
      total_cnt++;
      inst_word = NOP;
   endtask

   task automatic test_stalls();
      logic exp_pe;
      trigger = 1'b0;
      ticks(4);
      if (busy !== 1'b1 || cyc_cnt !== 32'd0 || done !== 1'b0)
         $display("FAIL restart_from_halt: got busy=%b cyc=%0d done=%b want 1 0 0",
                  busy, cyc_cnt, done);
      else pass_cnt++;
      total_cnt++;
      trigger = 1'b1;
      // data_stall in cycles 1..3, du_stall in 2..3, halt word in stalled cycle 2.
      for (int i = 0; i < 6; i++) begin
         data_stall = (i >= 1 && i <= 3);
         du_stall   = (i == 2 || i == 3);
         inst_word  = (i == 2) ? 32'h0 : NOP;
         exp_pe     = !(i >= 1 && i <= 3);
         #1;
         if (proc_en !== exp_pe)
            $display("FAIL stall_pe_cycle%0d: got %b want %b", i, proc_en, exp_pe);
         else pass_cnt++;
         total_cnt++;
         tick();
      end
      data_stall = 1'b0;
      du_stall   = 1'b0;
      inst_word  = NOP;
      if (cyc_cnt !== 32'd3 || stall_cnt !== 32'd3 || busy !== 1'b1)
         $display("FAIL stall_counts: got cyc=%0d st=%0d busy=%b want 3 3 1",
                  cyc_cnt, stall_cnt, busy);
      else pass_cnt++;
      total_cnt++;
   endtask

   task automatic test_watchdog();
      ticks(12);
      if (busy !== 1'b1 || cyc_cnt !== 32'd15)
         $display("FAIL wdog_pre: got busy=%b cyc=%0d want 1 15", busy, cyc_cnt);
      else pass_cnt++;
      total_cnt++;
      tick();
      if ({done, timeout} !== 2'b11 || cyc_cnt !== 32'd16 || stall_cnt !== 32'd3)
         $display("FAIL wdog_halt: got done/to=%b cyc=%0d st=%0d want 11 16 3",
                  {done, timeout}, cyc_cnt, stall_cnt);
      else pass_cnt++;
      total_cnt++;
      trigger = 1'b0;
      ticks(3);
      if (timeout !== 1'b1 || done !== 1'b1)
         $display("FAIL wdog_sticky: got to=%b done=%b want 1 1", timeout, done);
      else pass_cnt++;
      total_cnt++;
      tick();
      if (busy !== 1'b1 || timeout !== 1'b0 || cyc_cnt !== 32'd0 || stall_cnt !== 32'd0)
         $display("FAIL wdog_restart: got busy=%b to=%b cyc=%0d st=%0d want 1 0 0 0",
                  busy, timeout, cyc_cnt, stall_cnt);
      else pass_cnt++;
      total_cnt++;
      trigger = 1'b1;
      // Zero word on the last allowed cycle: both halt causes at once.
      ticks(15);
      inst_word = 32'h0;
      tick();
      if ({done, timeout} !== 2'b11 || cyc_cnt !== 32'd16)
         $display("FAIL wdog_and_zero: got done/to=%b cyc=%0d want 11 16",
                  {done, timeout}, cyc_cnt);
      else pass_cnt++;
      total_cnt++;
      inst_word = NOP;
   endtask

   task automatic test_held_trigger();
      trigger = 1'b0;
      rst_n   = 1'b0;
      ticks(2);
      if ({busy, done, timeout} !== 3'b000 || cyc_cnt !== 32'd0)
         $display("FAIL reset_from_halt: got busy/done/to=%b cyc=%0d want 000 0",
                  {busy, done, timeout}, cyc_cnt);
      else pass_cnt++;
      total_cnt++;
      rst_n = 1'b1;
      ticks(10);
      if (busy !== 1'b0 || done !== 1'b0)
         $display("FAIL held_through_reset: got busy=%b done=%b want 0 0", busy, done);
      else pass_cnt++;
      total_cnt++;
      trigger = 1'b1;
      ticks(4);
      trigger = 1'b0;
      ticks(4);
      if (busy !== 1'b1) $display("FAIL press_after_release: got busy=%b want 1", busy);
      else pass_cnt++;
      total_cnt++;
      inst_word = 32'h0;
      tick();
      inst_word = NOP;
      ticks(10);
      if (done !== 1'b1 || busy !== 1'b0)
         $display("FAIL held_through_halt: got done=%b busy=%b want 1 0", done, busy);
      else pass_cnt++;
      total_cnt++;
      trigger = 1'b1;
      ticks(4);
      trigger = 1'b0;
      ticks(4);
      if (busy !== 1'b1 || cyc_cnt !== 32'd0)
         $display("FAIL repress_start: got busy=%b cyc=%0d want 1 0", busy, cyc_cnt);
      else pass_cnt++;
      total_cnt++;
      trigger = 1'b1;
      ticks(3);
      if (cyc_cnt !== 32'd3) $display("FAIL midrun_cyc: got %0d want 3", cyc_cnt);
      else pass_cnt++;
      total_cnt++;
      rst_n = 1'b0;
      tick();
      if ({run_en, busy, done} !== 3'b000 || cyc_cnt !== 32'd0 || stall_cnt !== 32'd0)
         $display("FAIL midrun_reset: got run/busy/done=%b cyc=%0d st=%0d want 000 0 0",
                  {run_en, busy, done}, cyc_cnt, stall_cnt);
      else pass_cnt++;
      total_cnt++;
      rst_n = 1'b1;
      ticks(2);
   endtask

   initial begin
      test_reset();
      test_start_latency();
      test_halt_on_zero();
      test_stalls();
      test_watchdog();
      test_held_trigger();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
